uart_loopback_checker: RTL
==========================

UART_LOOPBACK_CHECKER -- requirements
Module: uart_loopback_checker

Interface
REQ-001 Parameter: CLK_FREQ, 50000000, clock frequency in Hz (informational; used to derive the default timeout).
REQ-002 Parameter: TIMEOUT_CYCLES, CLK_FREQ/100, idle cycles allowed while echoes are outstanding.
REQ-003 Parameter: MAX_OUTSTANDING, 16, expected-byte queue depth (power of two, 2..256).
REQ-004 Parameter: SEED, 8'h01, non-zero LFSR seed.
REQ-005 Parameter: INVERT_CASE, 1, when 1 the expected echo is the case-inverted sent byte; when 0 it is the sent byte unchanged.
REQ-006 Port: clk, input, 1, sole clock.
REQ-007 Port: sresetn, input, 1, reset that is asynchronous and active-low.
REQ-008 Port: start, input, 1, single-cycle request to begin a test run.
REQ-009 Port: num_bytes, input, 16, byte count sampled with start.
REQ-010 Port: m_axis_tready, input, 1, ready from the UART transmitter.
REQ-011 Port: m_axis_tvalid, output, 1, byte valid toward the transmitter.
REQ-012 Port: m_axis_tdata, output, 8, byte toward the transmitter.
REQ-013 Port: rx_valid, input, 1, single-cycle strobe from the UART receiver.
REQ-014 Port: rx_data, input, 8, received byte; valid only with rx_valid.
REQ-015 Port: busy, output, 1, high in RUN and DRAIN.
REQ-016 Port: done, output, 1, level, high in DONE.
REQ-017 Port: pass, output, 1, valid with done; high iff err_count==0, unexp_count==0 and timeout==0.
REQ-018 Port: err_count, output, 16, number of mismatched echoes.
REQ-019 Port: unexp_count, output, 16, number of bytes received with an empty queue.
REQ-020 Port: timeout, output, 1, run ended by timeout.

Function
REQ-021 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
- IDLE/DONE -> RUN: start high. Counters, timeout, queue and LFSR (reloaded with SEED) are cleared on the same edge; num_bytes is latched.
- start seen in RUN or DRAIN: ignored.
REQ-022 If num_bytes==0 at start, the FSM SHALL go directly to DONE one cycle later, with pass=1.
REQ-023 Transmit handshake in RUN:
- m_axis_tvalid is high while sent<num_bytes and queue occupancy<MAX_OUTSTANDING.
- m_axis_tdata equals the LFSR state and is held stable until m_axis_tready.
- tvalid is not withdrawn before acceptance once asserted.
REQ-024 The LFSR SHALL be 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1 (mask 8'hB8), shift right, and advance only on an accepted beat.
REQ-025 On each accepted beat, the expected byte (case_invert(tdata) or tdata per INVERT_CASE) SHALL be pushed to the queue.
REQ-026 case_invert SHALL XOR 8'h20 for bytes 8'h41-8'h5A and 8'h61-8'h7A, and pass every other byte unchanged.
REQ-027 Receive handling:
- rx_valid with the queue non-empty: pop the head and compare; on mismatch, err_count increments.
- rx_valid with the queue empty: unexp_count increments.
- Both counters saturate at 16'hFFFF.
- rx is processed in IDLE/DONE only for unexp_count.
REQ-028 Simultaneous push and pop in the same cycle SHALL leave occupancy unchanged; pop-side compare uses the pre-cycle head, including when occupancy==1.
REQ-029 RUN -> DRAIN when sent==num_bytes.
REQ-030 DRAIN -> DONE when the queue is empty.
REQ-031 Timeout SHALL be handled as follows:
- The idle counter runs in RUN/DRAIN while the queue is non-empty.
- It is cleared on any rx_valid or accepted beat.
- Reaching TIMEOUT_CYCLES sets timeout=1 and forces DONE; queue contents are discarded.
REQ-032 All outputs SHALL be registered; done/pass assert on the first cycle in DONE.

Reset
REQ-033 On sresetn low, the block SHALL asynchronously force:
- state IDLE
- m_axis_tvalid=0, m_axis_tdata=0
- busy=0, done=0, pass=0, timeout=0
- err_count=0, unexp_count=0
- queue empty, LFSR=SEED
REQ-034 Reset asserted mid-run SHALL abandon the run immediately, and no beat SHALL be presented after reset deassertion until a new start.

Structure
REQ-035 A shared package uart_loopback_pkg SHALL hold the state enum type, the LFSR mask constant and the case_invert function.
REQ-036 The expected-byte queue SHALL be one sub-module, byte_queue (DEPTH parameter, push/pop/empty/full/count, same-cycle push+pop legal); everything else lives in uart_loopback_checker.

Verification
REQ-037 Echo bench: num_bytes=200, rx returns case_invert of each beat 100 cycles later -> done, pass=1, err_count=0, unexp_count=0.
REQ-038 Corruption bench: num_bytes=50, byte 10 echoed XOR 8'h01 -> done, err_count=1, pass=0.
REQ-039 Backpressure bench: tready low for 64 cycles and echoes withheld -> m_axis_tvalid stays low once 16 bytes are outstanding, and tdata is stable while stalled.
REQ-040 Timeout bench: TIMEOUT_CYCLES=1000, echoes stop after byte 5 of 20 -> timeout=1 and done exactly 1000 cycles after the last activity.
REQ-041 Edge bench: one spurious rx in IDLE, then start with num_bytes=0 -> done one cycle later with unexp_count=0 (cleared by start), pass=1.
REQ-042 Reset bench: sresetn pulsed low mid-RUN -> all outputs return to reset values within the same cycle, and a fresh start re-emits the SEED sequence from 8'h01.

Source files
------------

// File: rtl/uart_loopback_pkg.sv
// Shared types and helpers for the UART loopback checker.
//   state_t      : run-control FSM states
//   LFSR_MASK    : Galois feedback mask for x^8+x^6+x^5+x^4+1 (shift right)
//   case_invert  : flips ASCII letter case, passes other bytes through
//   lfsr_step    : one Galois LFSR advance
//   sat_inc16    : 16-bit increment that sticks at 16'hFFFF
package uart_loopback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_MASK = 8'hB8;

    function automatic logic [7:0] case_invert(input logic [7:0] b);
        logic [7:0] r;
        if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A))) begin
            r = b ^ 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic [7:0] r;
        if (s[0]) begin
            r = (s >> 1) ^ LFSR_MASK;
        end else begin
            r = s >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_loopback_checker_byte_queue.sv
// Expected-byte FIFO for the loopback checker.
//   clk, sresetn      : clock, async active-low reset
//   clear             : synchronous flush (wins over push/pop)
//   push, push_data   : write one byte (ignored when full unless popping)
//   pop               : discard head (ignored when empty)
//   head              : current head byte (pre-edge value)
//   empty, full, count: occupancy status
// Same-cycle push and pop is legal and leaves count unchanged.
module byte_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       sresetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify push/pop against occupancy
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
    end

    // Storage write; the array needs no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign full  = (count_r == FULL_CNT);
    assign count = count_r;

endmodule

// File: rtl/uart_loopback_checker.sv
// UART loopback checker: streams LFSR bytes to a UART transmitter, expects
// each byte (optionally case-inverted) to come back on the receiver strobe,
// and reports mismatches, unexpected bytes and echo timeouts.
//   clk, sresetn                      : clock, async active-low reset
//   start, num_bytes                  : launch a run of num_bytes beats
//   m_axis_tvalid/tready/tdata        : byte stream toward the transmitter
//   rx_valid, rx_data                 : echo strobe from the receiver
//   busy, done, pass                  : run status (all registered)
//   err_count, unexp_count, timeout   : result detail (all registered)
module uart_loopback_checker
    import uart_loopback_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50000000,
    parameter int unsigned TIMEOUT_CYCLES  = CLK_FREQ / 100,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter logic [7:0]  SEED            = 8'h01,
    parameter bit          INVERT_CASE     = 1'b1
) (
    input  logic        clk,
    input  logic        sresetn,
    input  logic        start,
    input  logic [15:0] num_bytes,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] unexp_count,
    output logic        timeout
);

    localparam int unsigned CW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW:0] MAX_OCC  = MAX_OUTSTANDING[CW:0];
    localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

    state_t        state_r, state_nxt_s;
    logic [7:0]    lfsr_r, lfsr_nxt_s;
    logic [15:0]   sent_r, sent_nxt_s;
    logic [15:0]   num_r, num_nxt_s;
    logic [31:0]   idle_r, idle_nxt_s;
    logic [15:0]   err_r, err_nxt_s;
    logic [15:0]   unexp_r, unexp_nxt_s;
    logic          timeout_r, timeout_nxt_s;
    logic          tvalid_r, tvalid_nxt_s;
    logic [7:0]    tdata_r;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;
    logic          pass_r, pass_nxt_s;
    logic          beat_s;
    logic [CW:0]   occ_nxt_s;

    logic          q_clear_s;
    logic          q_push_s;
    logic [7:0]    q_push_data_s;
    logic          q_pop_s;
    logic [7:0]    q_head_s;
    logic          q_empty_s;
    logic          q_full_s;
    logic [CW-1:0] q_count_s;

    byte_queue #(.DEPTH(MAX_OUTSTANDING)) u_queue (
        .clk       (clk),
        .sresetn   (sresetn),
        .clear     (q_clear_s),
        .push      (q_push_s),
        .push_data (q_push_data_s),
        .pop       (q_pop_s),
        .head      (q_head_s),
        .empty     (q_empty_s),
        .full      (q_full_s),
        .count     (q_count_s)
    );

    // Next-state, counters, queue control and LFSR advance
    always_comb begin
        state_nxt_s   = state_r;
        lfsr_nxt_s    = lfsr_r;
        sent_nxt_s    = sent_r;
        num_nxt_s     = num_r;
        idle_nxt_s    = idle_r;
        err_nxt_s     = err_r;
        unexp_nxt_s   = unexp_r;
        timeout_nxt_s = timeout_r;
        q_clear_s     = 1'b0;
        q_push_s      = 1'b0;
        q_pop_s       = 1'b0;
        beat_s        = tvalid_r && m_axis_tready;
        q_push_data_s = INVERT_CASE ? case_invert(tdata_r) : tdata_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_nxt_s    = SEED;
                    sent_nxt_s    = 16'd0;
                    num_nxt_s     = num_bytes;
                    idle_nxt_s    = 32'd0;
                    err_nxt_s     = 16'd0;
                    unexp_nxt_s   = 16'd0;
                    timeout_nxt_s = 1'b0;
                    q_clear_s     = 1'b1;
                    if (num_bytes == 16'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (rx_valid) begin
                    // nothing is outstanding outside a run
                    unexp_nxt_s = sat_inc16(unexp_r);
                end else begin
                    unexp_nxt_s = unexp_r;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (beat_s) begin
                    q_push_s   = !q_full_s;
                    lfsr_nxt_s = lfsr_step(lfsr_r);
                    sent_nxt_s = sent_r + 16'd1;
                end else begin
                    q_push_s = 1'b0;
                end
                // compare against the head as it stood before this edge
                if (rx_valid && !q_empty_s) begin
                    q_pop_s = 1'b1;
                    if (q_head_s != rx_data) begin
                        err_nxt_s = sat_inc16(err_r);
                    end else begin
                        err_nxt_s = err_r;
                    end
                end else if (rx_valid) begin
                    unexp_nxt_s = sat_inc16(unexp_r);
                end else begin
                    unexp_nxt_s = unexp_r;
                end
                if (beat_s || rx_valid) begin
                    idle_nxt_s = 32'd0;
                end else if (!q_empty_s) begin
                    idle_nxt_s = idle_r + 32'd1;
                end else begin
                    idle_nxt_s = idle_r;
                end
                if (idle_nxt_s >= TO_LIMIT) begin
                    timeout_nxt_s = 1'b1;
                    q_clear_s     = 1'b1;
                    idle_nxt_s    = 32'd0;
                    state_nxt_s   = ST_DONE;
                end else if ((state_r == ST_RUN) && (sent_r == num_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else if ((state_r == ST_DRAIN) && q_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output look-ahead so every port comes straight from a flop
    always_comb begin
        occ_nxt_s = '0;
        if (q_clear_s) begin
            occ_nxt_s = '0;
        end else begin
            occ_nxt_s = {1'b0, q_count_s} + {{CW{1'b0}}, q_push_s} - {{CW{1'b0}}, q_pop_s};
        end
        tvalid_nxt_s = (state_nxt_s == ST_RUN) && (sent_nxt_s < num_nxt_s) && (occ_nxt_s < MAX_OCC);
        busy_nxt_s   = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
        done_nxt_s   = (state_nxt_s == ST_DONE);
        pass_nxt_s   = done_nxt_s && (err_nxt_s == 16'd0) && (unexp_nxt_s == 16'd0) && !timeout_nxt_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= SEED;
            sent_r    <= 16'd0;
            num_r     <= 16'd0;
            idle_r    <= 32'd0;
            err_r     <= 16'd0;
            unexp_r   <= 16'd0;
            timeout_r <= 1'b0;
            tvalid_r  <= 1'b0;
            tdata_r   <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            sent_r    <= sent_nxt_s;
            num_r     <= num_nxt_s;
            idle_r    <= idle_nxt_s;
            err_r     <= err_nxt_s;
            unexp_r   <= unexp_nxt_s;
            timeout_r <= timeout_nxt_s;
            tvalid_r  <= tvalid_nxt_s;
            tdata_r   <= lfsr_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign unexp_count   = unexp_r;
    assign timeout       = timeout_r;

endmodule
